// File: rtl/instruction_fetch_decoder_if.sv
// Fetch/issue bus of the instruction front end: memory request/response
// channel, scheduler control (stall, flush) and the decoded issue fields.
interface instruction_fetch_decoder_if;
  // Memory request / response channel
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  // Scheduler control
  logic        csu_stall;
  logic        flush_pipline;
  logic [31:0] flush_target_pc;

  // Issue channel towards the scheduler
  logic        ins_just_issued;
  logic [31:0] issue_PC;
  logic [31:0] ins_issued;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic [6:0]  issue_funct7;
  logic [31:0] issue_imm_val;
  logic [5:0]  issue_shamt_val;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;

  // Front-end side
  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    input  csu_stall, flush_pipline, flush_target_pc,
    output ins_just_issued, issue_PC, ins_issued, issue_opcode, issue_funct3,
    output issue_funct7, issue_imm_val, issue_shamt_val, issue_rs1, issue_rs2, issue_rd
  );

  // Memory controller / scheduler side
  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    output csu_stall, flush_pipline, flush_target_pc,
    input  ins_just_issued, issue_PC, ins_issued, issue_opcode, issue_funct3,
    input  issue_funct7, issue_imm_val, issue_shamt_val, issue_rs1, issue_rs2, issue_rd
  );
endinterface

// File: rtl/instruction_fetch_decoder.sv
// Instruction front end: sequential fetch (PC+4) into an in-order queue,
// decode of the queue head and one registered issue per cycle. The only
// redirect is a flush from the scheduler; one memory request is outstanding
// at most, and a request made stale by a flush has its response discarded.
module instruction_fetch_decoder #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic                         clk_in,
  input logic                         rst_in,
  input logic                         rdy_in,
  instruction_fetch_decoder_if.master bus
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } issue_t;

  // Split a queue entry into its issue fields; immediate chosen by opcode format
  function automatic issue_t decode(input entry_t e);
    issue_t      d;
    logic [31:0] w;
    w        = e.word;
    d.pc     = e.pc;
    d.word   = w;
    d.opcode = w[6:0];
    d.funct3 = w[14:12];
    d.funct7 = w[31:25];
    d.shamt  = {1'b0, w[24:20]};
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.rd     = w[11:7];
    case (w[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: d.imm = {{20{w[31]}}, w[31:20]};
      OPC_STORE:                      d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
      OPC_BRANCH:                     d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:             d.imm = {w[31:12], 12'b0};
      OPC_JAL:                        d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:                        d.imm = 32'h0;
    endcase
    return d;
  endfunction

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             issued_q, issued_d;
  issue_t           issue_q, issue_d;

  entry_t           queue_mem [QUEUE_DEPTH];
  entry_t           head;
  logic             flush;
  logic             pop;
  logic             push;
  logic             accept;
  logic             resp;

  assign flush  = bus.flush_pipline;
  assign head   = queue_mem[rd_ptr_q];
  assign accept = (state_q == S_REQ) && bus.mem_req_ready;
  assign resp   = (state_q == S_WAIT) && bus.mem_resp_valid;
  // A flush suppresses the issue candidate of its own cycle
  assign pop    = (count_q != '0) && !bus.csu_stall && !flush;

  // Fetch FSM: request gating, PC advance, stale-response dropping, redirect
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A flush in IDLE waits one cycle so the first request uses the new PC
        if (!flush && (count_q < DEPTH_CNT)) begin
          state_d    = S_REQ;
          req_addr_d = fetch_pc_q;
        end
      end

      S_REQ: begin
        if (accept) begin
          state_d = S_WAIT;
          // A stale request (flushed before acceptance) does not advance the PC
          if (!drop_q && !flush) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
          if (flush) begin
            drop_d = 1'b1;
          end
        end else if (flush) begin
          // Request stays up with its original address; its response is dropped
          drop_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (resp) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            push = 1'b1;
            // Space left after this push and this cycle's pop: request again right away
            if ((count_q + CNT_W'(1) - CNT_W'(pop)) < DEPTH_CNT) begin
              state_d    = S_REQ;
              req_addr_d = fetch_pc_q;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      fetch_pc_d = bus.flush_target_pc;
    end
  end

  // Queue bookkeeping: circular pointers wrap naturally; flush empties the queue
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Issue register: decoded head on a pop, otherwise fields hold and the pulse drops
  always_comb begin
    issued_d = pop;
    issue_d  = issue_q;
    if (pop) begin
      issue_d = decode(head);
    end
  end

  // State registers: synchronous active-low reset; rdy_in low holds everything
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_in) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      issued_q   <= 1'b0;
      issue_q    <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      issue_q    <= issue_d;
    end
  end

  // Queue storage: one entry written per accepted, non-stale response
  always_ff @(posedge clk_in) begin
    // NOTE: the storage array has no reset; count and pointers alone decide which entries are live.
    if (rst_in && rdy_in && push) begin
      queue_mem[wr_ptr_q] <= '{pc: req_addr_q, word: bus.mem_resp_data};
    end
  end

  assign bus.mem_req_valid   = (state_q == S_REQ);
  assign bus.mem_req_addr    = req_addr_q;

  assign bus.ins_just_issued = issued_q;
  assign bus.issue_PC        = issue_q.pc;
  assign bus.ins_issued      = issue_q.word;
  assign bus.issue_opcode    = issue_q.opcode;
  assign bus.issue_funct3    = issue_q.funct3;
  assign bus.issue_funct7    = issue_q.funct7;
  assign bus.issue_imm_val   = issue_q.imm;
  assign bus.issue_shamt_val = issue_q.shamt;
  assign bus.issue_rs1       = issue_q.rs1;
  assign bus.issue_rs2       = issue_q.rs2;
  assign bus.issue_rd        = issue_q.rd;

endmodule

// File: tb/tb_instruction_fetch_decoder.sv
// Bench for instruction_fetch_decoder: a randomized memory model answers
// fetches from a fixed program image, and a scoreboard holds the expected
// program-order issue stream (restarted at reset and on every flush). A
// monitor compares each issue, reset values and frozen outputs while rdy_in is low.
module tb_instruction_fetch_decoder;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  instruction_fetch_decoder_if bus ();

  instruction_fetch_decoder #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (RESET_PC)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int issues_seen = 0;

  logic [31:0] prog [256];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [5:0]  shamt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } dec_t;

  dec_t exp_q[$];

  // Memory model controls, set by the stimulus process
  int ready_pct = 60;
  int max_lat   = 2;
  bit hold_resp = 1'b0;
  bit mem_pending = 1'b0;
  bit mem_drove_resp = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode of the program word at pc, computed with plain integer arithmetic
  function automatic dec_t model_decode(input logic [31:0] pc);
    dec_t        d;
    logic [31:0] w;
    int          imm;
    w        = prog[pc[9:2]];
    d.pc     = pc;
    d.word   = w;
    d.opcode = w[6:0];
    d.funct3 = w[14:12];
    d.funct7 = w[31:25];
    d.shamt  = {1'b0, w[24:20]};
    d.rs1    = w[19:15];
    d.rs2    = w[24:20];
    d.rd     = w[11:7];
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: imm = int'($signed(w)) >>> 20;
      7'b0100011: imm = (int'($signed(w)) >>> 25) * 32 + int'(w[11:7]);
      7'b1100011: imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                        + int'(w[11:8]) * 2;
      7'b0110111, 7'b0010111: imm = int'(w & 32'hFFFFF000);
      7'b1101111: imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                        + int'(w[30:21]) * 2;
      default: imm = 0;
    endcase
    d.imm = 32'(imm);
    return d;
  endfunction

  // Expected stream: program order starting at a given PC
  task automatic reload(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 600; i++) begin
      exp_q.push_back(model_decode(start + 32'(4 * i)));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Wait (bounded) for a visible fetch request and check its address
  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    int n;
    n = 0;
    while (!bus.mem_req_valid && n < 100) begin
      tick(1);
      n++;
    end
    check(name, {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, exp_addr});
  endtask

  // Memory model: decides ready/response for the coming edge at each negedge
  initial begin : mem_model
    bit          drove_ready;
    bit          prev_valid;
    logic [31:0] prev_addr;
    logic [31:0] pend_addr;
    int          lat;
    bit          edge_rdy;
    bit          edge_rst_ok;
    drove_ready = 1'b0;
    prev_valid  = 1'b0;
    prev_addr   = '0;
    pend_addr   = '0;
    lat         = 0;
    edge_rdy    = 1'b0;
    edge_rst_ok = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk_in);
      if (!edge_rst_ok) begin
        mem_pending = 1'b0;
      end else if (edge_rdy) begin
        if (mem_drove_resp) mem_pending = 1'b0;
        if (drove_ready && prev_valid) begin
          check("one_outstanding", 256'(mem_pending), 256'(0));
          mem_pending = 1'b1;
          pend_addr   = prev_addr;
          lat         = $urandom_range(max_lat, 0);
        end
      end
      if (edge_rst_ok && prev_valid && !(drove_ready && edge_rdy)) begin
        check("req_hold", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, prev_addr});
      end
      if (bus.mem_req_valid) begin
        check("req_align", 256'(bus.mem_req_addr[1:0]), 256'(0));
      end
      if (mem_pending && lat > 0) lat--;
      mem_drove_resp     = mem_pending && (lat == 0) && !hold_resp;
      bus.mem_resp_valid = mem_drove_resp;
      bus.mem_resp_data  = mem_drove_resp ? prog[pend_addr[9:2]] : $urandom;
      drove_ready        = ($urandom_range(99, 0) < ready_pct);
      bus.mem_req_ready  = drove_ready;
      prev_valid         = bus.mem_req_valid;
      prev_addr          = bus.mem_req_addr;
      edge_rdy           = rdy_in;
      edge_rst_ok        = rst_in;
    end
  end

  // Monitor: compares outputs produced by the previous edge, then notes redirects
  initial begin : monitor
    bit           m_edge_rdy;
    bit           m_edge_rst;
    logic [129:0] snap;
    logic [129:0] now_v;
    dec_t         act;
    dec_t         exp;
    m_edge_rdy = 1'b1;
    m_edge_rst = 1'b0;
    snap       = '0;
    forever begin
      @(negedge clk_in);
      now_v = {bus.ins_just_issued, bus.issue_PC, bus.ins_issued, bus.issue_imm_val,
               bus.mem_req_valid, bus.mem_req_addr};
      if (!m_edge_rst) begin
        check("reset_outputs",
              {bus.ins_just_issued, bus.issue_PC, bus.ins_issued, bus.issue_opcode,
               bus.issue_funct3, bus.issue_funct7, bus.issue_imm_val, bus.issue_shamt_val,
               bus.issue_rs1, bus.issue_rs2, bus.issue_rd, bus.mem_req_valid, bus.mem_req_addr},
              {136'h0, RESET_PC});
      end else if (!m_edge_rdy) begin
        check("frozen_outputs", 256'(now_v), 256'(snap));
      end else if (bus.ins_just_issued) begin
        act = '{pc: bus.issue_PC, word: bus.ins_issued, opcode: bus.issue_opcode,
                funct3: bus.issue_funct3, funct7: bus.issue_funct7, imm: bus.issue_imm_val,
                shamt: bus.issue_shamt_val, rs1: bus.issue_rs1, rs2: bus.issue_rs2,
                rd: bus.issue_rd};
        if (exp_q.size() == 0) begin
          check("issue_unexpected", 256'(act), 256'(0));
        end else begin
          exp = exp_q.pop_front();
          check("issue", 256'(act), 256'(exp));
          issues_seen++;
          if (act.word == 32'hFFF00093) begin
            check("addi_imm_rd", {act.imm, act.rd}, {32'hFFFFFFFF, 5'd1});
          end
          // beq x0,x0,-4
          if (act.word == 32'hFE000EE3) begin
            check("beq_imm", 256'(act.imm), 256'(32'hFFFFFFFC));
          end
        end
      end
      snap = now_v;
      if (!rst_in) begin
        reload(RESET_PC);
      end else if (rdy_in && bus.flush_pipline) begin
        reload(bus.flush_target_pc);
      end
      m_edge_rdy = rdy_in;
      m_edge_rst = rst_in;
    end
  end

  // Stimulus
  initial begin : stimulus
    logic [6:0]  ops [10];
    logic [31:0] r;
    int          n;
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
    for (int i = 0; i < 256; i++) begin
      r       = $urandom;
      prog[i] = {r[31:7], ops[$urandom_range(9, 0)]};
    end
    prog[1] = 32'hFFF00093;
    prog[2] = 32'hFE000EE3;

    rst_in              = 1'b0;
    rdy_in              = 1'b1;
    bus.csu_stall       = 1'b0;
    bus.flush_pipline   = 1'b0;
    bus.flush_target_pc = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // Sequential fetch from reset
    wait_req("first_req_addr", RESET_PC);
    tick(40);

    // Randomized stall / freeze / flush traffic
    for (int c = 0; c < 400; c++) begin
      bus.csu_stall       = ($urandom_range(99, 0) < 30);
      rdy_in              = ($urandom_range(99, 0) >= 6);
      bus.flush_pipline   = ($urandom_range(99, 0) < 3);
      bus.flush_target_pc = {22'b0, 8'($urandom_range(255, 0)), 2'b00};
      tick(1);
    end
    bus.flush_pipline = 1'b0;
    bus.csu_stall     = 1'b0;
    rdy_in            = 1'b1;
    tick(10);

    // Long stall: queue fills, fetch stops, then four back-to-back issues
    ready_pct     = 100;
    max_lat       = 1;
    bus.csu_stall = 1'b1;
    tick(20);
    check("stall_no_req", {bus.mem_req_valid, mem_pending}, 2'b00);
    bus.csu_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("b2b_issue", 256'(bus.ins_just_issued), 256'(1));
    end
    ready_pct = 60;
    max_lat   = 2;
    tick(10);

    // Flush while a response is outstanding; its late response must be dropped
    hold_resp = 1'b1;
    n = 0;
    while (!(mem_pending && !mem_drove_resp) && n < 100) begin
      tick(1);
      n++;
    end
    check("wait_state_reached", 256'(mem_pending), 256'(1));
    bus.flush_pipline   = 1'b1;
    bus.flush_target_pc = 32'h100;
    tick(1);
    bus.flush_pipline = 1'b0;
    tick(3);
    hold_resp = 1'b0;
    wait_req("flush_req_addr", 32'h100);
    tick(20);

    // Decode examples at 0x4 and 0x8
    bus.flush_pipline   = 1'b1;
    bus.flush_target_pc = 32'h4;
    tick(1);
    bus.flush_pipline = 1'b0;
    tick(30);

    // Freeze during REQ, then during WAIT
    wait_req("freeze_req_seen", bus.mem_req_addr);
    rdy_in = 1'b0;
    tick(5);
    rdy_in = 1'b1;
    n = 0;
    while (!mem_pending && n < 100) begin
      tick(1);
      n++;
    end
    rdy_in = 1'b0;
    tick(5);
    rdy_in = 1'b1;
    tick(20);

    // Reset with a full queue: everything clears, fetch restarts at RESET_PC
    ready_pct     = 100;
    bus.csu_stall = 1'b1;
    tick(20);
    rst_in = 1'b0;
    tick(1);
    rst_in        = 1'b1;
    bus.csu_stall = 1'b0;
    ready_pct     = 60;
    wait_req("reset_refetch_addr", RESET_PC);
    tick(60);

    check("issues_seen_enough", 256'(issues_seen > 100), 256'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
